// File: rtl/fp_special_pkg.sv
// Shared encodings for the floating-point special-case pipeline.
package fp_special_pkg;

  // Operation select, shared by all lanes of a beat
  typedef enum logic [1:0] {
    MODE_MUL = 2'b00,
    MODE_DIV = 2'b01,
    MODE_ADD = 2'b10,
    MODE_SUB = 2'b11
  } mode_e;

  localparam int unsigned MODE_W = 2;

  // Per-lane status vector: [nan, inf, zero, invalid, div_zero]
  localparam int unsigned STATUS_W    = 5;
  localparam int unsigned ST_NAN      = 4;
  localparam int unsigned ST_INF      = 3;
  localparam int unsigned ST_ZERO     = 2;
  localparam int unsigned ST_INVALID  = 1;
  localparam int unsigned ST_DIV_ZERO = 0;

  // One-hot operand class vector
  localparam int unsigned CLS_W      = 6;
  localparam int unsigned CLS_QNAN   = 5;
  localparam int unsigned CLS_SNAN   = 4;
  localparam int unsigned CLS_INF    = 3;
  localparam int unsigned CLS_DENORM = 2;
  localparam int unsigned CLS_NORM   = 1;
  localparam int unsigned CLS_ZERO   = 0;

endpackage

// File: rtl/fp_classify.sv
// Combinational one-hot classifier for the exponent/mantissa of one operand.
module fp_classify
  import fp_special_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0] mag,
  output logic [CLS_W-1:0]                cls_c
);

  logic [EXP_WIDTH-1:0]  exp_f;
  logic [MANT_WIDTH-1:0] mant_f;
  logic                  exp_ones;
  logic                  exp_zero;
  logic                  mant_zero;
  logic                  mant_msb;

  assign exp_f     = mag[EXP_WIDTH+MANT_WIDTH-1 -: EXP_WIDTH];
  assign mant_f    = mag[MANT_WIDTH-1:0];
  assign exp_ones  = &exp_f;
  assign exp_zero  = ~|exp_f;
  assign mant_zero = ~|mant_f;
  assign mant_msb  = mant_f[MANT_WIDTH-1];

  // Exactly one class bit is set for any bit pattern
  always_comb begin
    cls_c             = '0;
    cls_c[CLS_QNAN]   = exp_ones & mant_msb;
    cls_c[CLS_SNAN]   = exp_ones & ~mant_msb & ~mant_zero;
    cls_c[CLS_INF]    = exp_ones & mant_zero;
    cls_c[CLS_DENORM] = exp_zero & ~mant_zero;
    cls_c[CLS_NORM]   = ~exp_ones & ~exp_zero;
    cls_c[CLS_ZERO]   = exp_zero & mant_zero;
  end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage, multi-lane IEEE special-case resolver with valid/ready flow
// control and sticky invalid / divide-by-zero flags.
module fp_special_pipe
  import fp_special_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 23,
  parameter int unsigned LANES      = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [MODE_W-1:0]                             in_mode,
  input  logic [LANES*(EXP_WIDTH+MANT_WIDTH+1)-1:0]     in_op1,
  input  logic [LANES*(EXP_WIDTH+MANT_WIDTH+1)-1:0]     in_op2,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [LANES-1:0]                              out_special,
  output logic [LANES*(EXP_WIDTH+MANT_WIDTH+1)-1:0]     out_result,
  output logic [LANES*STATUS_W-1:0]                     out_status,
  input  logic                                          flags_clr,
  output logic                                          sticky_invalid,
  output logic                                          sticky_div_zero
);

  localparam int unsigned W = EXP_WIDTH + MANT_WIDTH + 1;
  localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = '1;
  localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = '0;
  localparam logic [MANT_WIDTH-1:0] MANT_ZERO = '0;
  localparam logic [MANT_WIDTH-1:0] QNAN_MANT = {1'b1, {(MANT_WIDTH-1){1'b0}}};

  logic [LANES-1:0][CLS_W-1:0] cls1_c, cls2_c;
  logic [LANES-1:0]            sign1_c, sign2_c;

  logic                        s1_valid;
  mode_e                       s1_mode;
  logic [LANES-1:0][CLS_W-1:0] s1_cls1, s1_cls2;
  logic [LANES-1:0]            s1_sign1, s1_sign2;

  logic                           s2_move_c;
  logic [LANES-1:0][STATUS_W:0]   dec_c;
  logic [LANES-1:0]               d_special_c;
  logic [LANES-1:0][W-1:0]        d_result_c;
  logic [LANES-1:0][STATUS_W-1:0] d_status_c;
  logic                           set_inv_c;
  logic                           set_dz_c;

  // Two classifiers per lane, one per operand
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_classify #(
      .EXP_WIDTH (EXP_WIDTH),
      .MANT_WIDTH(MANT_WIDTH)
    ) u_cls1 (
      .mag  (in_op1[i*W +: W-1]),
      .cls_c(cls1_c[i])
    );
    fp_classify #(
      .EXP_WIDTH (EXP_WIDTH),
      .MANT_WIDTH(MANT_WIDTH)
    ) u_cls2 (
      .mag  (in_op2[i*W +: W-1]),
      .cls_c(cls2_c[i])
    );
    assign sign1_c[i] = in_op1[i*W + W-1];
    assign sign2_c[i] = in_op2[i*W + W-1];
  end

  // Stage 2 advances when empty or drained; stage 1 accepts when it can hand off
  assign s2_move_c = ~out_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_move_c;

  // Special-case rules for one lane; returns {result sign, status}
  function automatic logic [STATUS_W:0] lane_decide(
    input mode_e            mode,
    input logic [CLS_W-1:0] c1,
    input logic [CLS_W-1:0] c2,
    input logic             sa,
    input logic             sb
  );
    logic                nan1, nan2, inf1, inf2, zero1, zero2, fin1, fin2;
    logic                eb;
    logic                sign;
    logic [STATUS_W-1:0] st;
    st    = '0;
    sign  = sa ^ sb;
    nan1  = c1[CLS_QNAN] | c1[CLS_SNAN];
    nan2  = c2[CLS_QNAN] | c2[CLS_SNAN];
    inf1  = c1[CLS_INF];
    inf2  = c2[CLS_INF];
    zero1 = c1[CLS_ZERO];
    zero2 = c2[CLS_ZERO];
    fin1  = c1[CLS_NORM] | c1[CLS_DENORM];
    fin2  = c2[CLS_NORM] | c2[CLS_DENORM];
    eb    = sb ^ (mode == MODE_SUB);
    if (nan1 | nan2) begin
      st[ST_NAN]     = 1'b1;
      st[ST_INVALID] = c1[CLS_SNAN] | c2[CLS_SNAN];
    end else begin
      case (mode)
        MODE_MUL: begin
          if ((inf1 & zero2) | (zero1 & inf2)) begin
            st[ST_NAN]     = 1'b1;
            st[ST_INVALID] = 1'b1;
          end else if (inf1 | inf2) begin
            st[ST_INF] = 1'b1;
          end else if (zero1 | zero2) begin
            st[ST_ZERO] = 1'b1;
          end
        end
        MODE_DIV: begin
          if ((zero1 & zero2) | (inf1 & inf2)) begin
            st[ST_NAN]     = 1'b1;
            st[ST_INVALID] = 1'b1;
          end else if (fin1 & zero2) begin
            st[ST_INF]      = 1'b1;
            st[ST_DIV_ZERO] = 1'b1;
          end else if (inf1 & (fin2 | zero2)) begin
            st[ST_INF] = 1'b1;
          end else if ((zero1 & (fin2 | inf2)) | (fin1 & inf2)) begin
            st[ST_ZERO] = 1'b1;
          end
        end
        default: begin
          if (inf1 & inf2 & (sa != eb)) begin
            st[ST_NAN]     = 1'b1;
            st[ST_INVALID] = 1'b1;
          end else if (inf1) begin
            st[ST_INF] = 1'b1;
            sign       = sa;
          end else if (inf2) begin
            st[ST_INF] = 1'b1;
            sign       = eb;
          end else if (zero1 & zero2) begin
            st[ST_ZERO] = 1'b1;
            sign        = sa & eb;
          end
        end
      endcase
    end
    return {sign, st};
  endfunction

  // Stage-2 decisions built from stage-1 classes
  always_comb begin
    dec_c       = '0;
    d_special_c = '0;
    d_result_c  = '0;
    d_status_c  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dec_c[i]       = lane_decide(s1_mode, s1_cls1[i], s1_cls2[i], s1_sign1[i], s1_sign2[i]);
      d_status_c[i]  = dec_c[i][STATUS_W-1:0];
      d_special_c[i] = dec_c[i][ST_NAN] | dec_c[i][ST_INF] | dec_c[i][ST_ZERO];
      if (dec_c[i][ST_NAN]) begin
        d_result_c[i] = {1'b0, EXP_ONES, QNAN_MANT};
      end else if (dec_c[i][ST_INF]) begin
        d_result_c[i] = {dec_c[i][STATUS_W], EXP_ONES, MANT_ZERO};
      end else if (dec_c[i][ST_ZERO]) begin
        d_result_c[i] = {dec_c[i][STATUS_W], EXP_ZERO, MANT_ZERO};
      end
    end
  end

  // Exception events of the beat leaving on this cycle
  always_comb begin
    set_inv_c = 1'b0;
    set_dz_c  = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      set_inv_c = set_inv_c | out_status[i*STATUS_W + ST_INVALID];
      set_dz_c  = set_dz_c  | out_status[i*STATUS_W + ST_DIV_ZERO];
    end
    set_inv_c = set_inv_c & out_valid & out_ready;
    set_dz_c  = set_dz_c  & out_valid & out_ready;
  end

  // Stage 1: register operand classes, signs and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_MUL;
      s1_cls1  <= '0;
      s1_cls2  <= '0;
      s1_sign1 <= '0;
      s1_sign2 <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode  <= mode_e'(in_mode);
        s1_cls1  <= cls1_c;
        s1_cls2  <= cls2_c;
        s1_sign1 <= sign1_c;
        s1_sign2 <= sign2_c;
      end
    end
  end

  // Stage 2: register decisions; held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_special <= '0;
      out_result  <= '0;
      out_status  <= '0;
    end else if (s2_move_c) begin
      out_valid   <= s1_valid;
      out_special <= d_special_c;
      out_result  <= d_result_c;
      out_status  <= d_status_c;
    end
  end

  // Sticky flags: a set event in the same cycle as a clear keeps the flag high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_invalid  <= 1'b0;
      sticky_div_zero <= 1'b0;
    end else begin
      sticky_invalid  <= (sticky_invalid  & ~flags_clr) | set_inv_c;
      sticky_div_zero <= (sticky_div_zero & ~flags_clr) | set_dz_c;
    end
  end

endmodule

// File: tb/tb_fp_special_pipe.sv
// Randomised and directed bench for fp_special_pipe with a scoreboard model.
module tb_fp_special_pipe;

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned LN = 4;
  localparam int unsigned W  = EW + MW + 1;
  localparam int unsigned SW = 5;
  localparam logic [W-1:0] ONE  = 32'h3F800000;
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_mode = 2'b00;
  logic [LN*W-1:0] in_op1 = '0;
  logic [LN*W-1:0] in_op2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LN-1:0]   out_special;
  logic [LN*W-1:0] out_result;
  logic [LN*SW-1:0] out_status;
  logic            flags_clr = 1'b0;
  logic            sticky_invalid;
  logic            sticky_div_zero;

  fp_special_pipe #(.EXP_WIDTH(EW), .MANT_WIDTH(MW), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_op1(in_op1), .in_op2(in_op2),
    .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
    .out_result(out_result), .out_status(out_status), .flags_clr(flags_clr),
    .sticky_invalid(sticky_invalid), .sticky_div_zero(sticky_div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sp; logic [W-1:0] r; logic [SW-1:0] st; } lane_t;
  typedef struct { logic [LN-1:0] sp; logic [LN*W-1:0] res; logic [LN*SW-1:0] st; } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic st_inv_m = 1'b0;
  logic st_dz_m  = 1'b0;

  task automatic check(input string name, input logic [LN*W-1:0] act, input logic [LN*W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // 0 zero, 1 finite nonzero, 2 inf, 3 qnan, 4 snan
  function automatic int kind(input logic [W-1:0] x);
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    e = x[W-2:MW];
    m = x[MW-1:0];
    if (e == '1) return (m == '0) ? 2 : (m[MW-1] ? 3 : 4);
    if (e == '0 && m == '0) return 0;
    return 1;
  endfunction

  // Outcome of one lane: 0 ordinary, 1 nan, 2 inf, 3 zero
  function automatic lane_t model_lane(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b);
    int    ka, kb, outcome;
    logic  sa, sb, e2, rs, inv, dz;
    lane_t l;
    ka = kind(a); kb = kind(b);
    sa = a[W-1];  sb = b[W-1];
    rs = sa ^ sb; inv = 1'b0; dz = 1'b0; outcome = 0;
    if (ka >= 3 || kb >= 3) begin
      outcome = 1; inv = (ka == 4 || kb == 4);
    end else if (mode == 2'b00) begin
      if ((ka == 2 && kb == 0) || (ka == 0 && kb == 2)) begin outcome = 1; inv = 1'b1; end
      else if (ka == 2 || kb == 2) outcome = 2;
      else if (ka == 0 || kb == 0) outcome = 3;
    end else if (mode == 2'b01) begin
      if (ka == kb && (ka == 0 || ka == 2)) begin outcome = 1; inv = 1'b1; end
      else if (ka == 1 && kb == 0) begin outcome = 2; dz = 1'b1; end
      else if (ka == 2) outcome = 2;
      else if (ka == 0 || kb == 2) outcome = 3;
    end else begin
      e2 = sb ^ mode[0];
      if (ka == 2 && kb == 2 && sa != e2) begin outcome = 1; inv = 1'b1; end
      else if (ka == 2) begin outcome = 2; rs = sa; end
      else if (kb == 2) begin outcome = 2; rs = e2; end
      else if (ka == 0 && kb == 0) begin outcome = 3; rs = sa & e2; end
    end
    l.sp = (outcome != 0);
    case (outcome)
      1:       begin l.r = QNAN;                             l.st = {3'b100, inv, dz}; end
      2:       begin l.r = {rs, {EW{1'b1}}, {MW{1'b0}}};     l.st = {3'b010, inv, dz}; end
      3:       begin l.r = {rs, {(W-1){1'b0}}};              l.st = {3'b001, inv, dz}; end
      default: begin l.r = '0;                               l.st = '0; end
    endcase
    return l;
  endfunction

  function automatic exp_t model_beat(input logic [1:0] mode, input logic [LN*W-1:0] o1, input logic [LN*W-1:0] o2);
    exp_t  e;
    lane_t l;
    e.sp = '0; e.res = '0; e.st = '0;
    for (int i = 0; i < LN; i++) begin
      l = model_lane(mode, o1[i*W +: W], o2[i*W +: W]);
      e.sp[i] = l.sp;
      e.res[i*W +: W] = l.r;
      e.st[i*SW +: SW] = l.st;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    s = 1'($urandom);
    m = MW'($urandom);
    e = EW'($urandom_range(1, (1 << EW) - 2));
    case ($urandom_range(0, 7))
      0: begin e = '0; m = '0; end
      1: begin e = '0; m[0] = 1'b1; end
      2: begin e = '1; m = '0; end
      3: begin e = '1; m[MW-1] = 1'b1; end
      4: begin e = '1; m[MW-1] = 1'b0; m[0] = 1'b1; end
      default: ;
    endcase
    return {s, e, m};
  endfunction

  // Scoreboard: compares every visible output beat and the sticky flags
  always @(negedge clk) begin
    exp_t e;
    logic set_i, set_d;
    if (!rst_n) begin
      q.delete();
      st_inv_m = 1'b0;
      st_dz_m  = 1'b0;
      check("reset out_valid", out_valid, 0);
    end else begin
      set_i = 1'b0; set_d = 1'b0;
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("sticky_invalid", sticky_invalid, st_inv_m);
      check("sticky_div_zero", sticky_div_zero, st_dz_m);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected out_valid", out_valid, 0);
        end else begin
          e = q[0];
          check("out_special", out_special, e.sp);
          check("out_result", out_result, e.res);
          check("out_status", out_status, e.st);
          if (out_ready) begin
            for (int i = 0; i < LN; i++) begin
              set_i = set_i | e.st[i*SW + 1];
              set_d = set_d | e.st[i*SW];
            end
            void'(q.pop_front());
          end
        end
      end
      st_inv_m = (st_inv_m & ~flags_clr) | set_i;
      st_dz_m  = (st_dz_m  & ~flags_clr) | set_d;
      if (in_valid && in_ready) q.push_back(model_beat(in_mode, in_op1, in_op2));
    end
  end

  task automatic directed(input string name, input logic [1:0] mode, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic [SW-1:0] es,
                          input logic esp, input logic [1:0] esticky);
    int lat;
    bit got;
    @(posedge clk); #1;
    flags_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0; in_valid = 1'b1; in_mode = mode;
    in_op1 = {{(LN-1){ONE}}, a};
    in_op2 = {{(LN-1){ONE}}, b};
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1; else lat++;
    end
    if (!got) begin
      check({name, " timeout"}, out_valid, 1);
    end else begin
      check({name, " latency"}, lat, 2);
      check({name, " result"}, out_result[W-1:0], er);
      check({name, " status"}, out_status[SW-1:0], es);
      check({name, " special"}, out_special[0], esp);
      @(posedge clk); #1;
      @(negedge clk);
      check({name, " sticky"}, {sticky_invalid, sticky_div_zero}, esticky);
    end
  endtask

  logic [W*LN-1:0] b2b_o1 [8];
  logic [W*LN-1:0] b2b_o2 [8];
  logic [1:0]      b2b_m  [8];

  initial begin
    int  i, c;
    bit  saw_stall, pending;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_result", out_result, 0);
    check("rst out_status", out_status, 0);
    check("rst out_special", out_special, 0);
    check("rst sticky", {sticky_invalid, sticky_div_zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", in_ready, 1);

    directed("mul inf*0",   2'b00, 32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10010, 1'b1, 2'b10);
    directed("div 1/-0",    2'b01, 32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01001, 1'b1, 2'b01);
    directed("sub inf-inf", 2'b11, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10010, 1'b1, 2'b10);
    directed("add -0+-0",   2'b10, 32'h80000000, 32'h80000000, 32'h80000000, 5'b00100, 1'b1, 2'b00);
    directed("add snan",    2'b10, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10010, 1'b1, 2'b10);
    directed("add 1+2",     2'b10, 32'h3F800000, 32'h40000000, 32'h00000000, 5'b00000, 1'b0, 2'b00);
    directed("div 0/0",     2'b01, 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10010, 1'b1, 2'b10);
    directed("mul -2*inf",  2'b00, 32'hC0000000, 32'h7F800000, 32'hFF800000, 5'b01000, 1'b1, 2'b00);
    directed("div 1/inf",   2'b01, 32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00100, 1'b1, 2'b00);
    directed("sub -inf-inf",2'b11, 32'hFF800000, 32'h7F800000, 32'hFF800000, 5'b01000, 1'b1, 2'b00);
    directed("mul qnan*0",  2'b00, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b1, 2'b00);
    directed("div inf/0",   2'b01, 32'hFF800000, 32'h00000000, 32'hFF800000, 5'b01000, 1'b1, 2'b00);

    // Back-to-back beats with downstream stalled for three cycles
    for (int k = 0; k < 8; k++) begin
      b2b_m[k] = 2'($urandom);
      for (int l = 0; l < LN; l++) begin
        b2b_o1[k][l*W +: W] = rand_op();
        b2b_o2[k][l*W +: W] = rand_op();
      end
    end
    i = 0; c = 0; saw_stall = 0;
    while (i < 8 && c < 200) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 5);
      in_valid = 1'b1; in_mode = b2b_m[i]; in_op1 = b2b_o1[i]; in_op2 = b2b_o2[i];
      @(negedge clk);
      if (in_ready) i++; else saw_stall = 1;
      c++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("b2b accepted", i, 8);
    check("b2b in_ready stall", saw_stall, 1);
    repeat (4) @(posedge clk);

    // Reset with two beats in flight
    #1;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_op1 = {LN{ONE}}; in_op2 = {LN{ONE}};
    @(posedge clk); #1;
    in_op2 = {LN{32'h00000000}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset out_status", out_status, 0);
    check("midreset out_special", out_special, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post-reset no beat", out_valid, 0);
    end

    // Clear coinciding with an invalid beat leaving: set wins
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b10;
    in_op1 = {{(LN-1){ONE}}, 32'h7F800001}; in_op2 = {LN{ONE}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    @(negedge clk);
    check("clr vs set sticky_invalid", sticky_invalid, 1);
    @(posedge clk); #1;
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    @(negedge clk);
    check("clr sticky_invalid", sticky_invalid, 0);

    // Randomised traffic with random back-pressure and clears
    pending = 0;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 7);
      flags_clr = ($urandom_range(0, 19) == 0);
      if (!pending) begin
        if ($urandom_range(0, 9) < 7) begin
          in_valid = 1'b1;
          in_mode  = 2'($urandom);
          for (int l = 0; l < LN; l++) begin
            in_op1[l*W +: W] = rand_op();
            in_op2[l*W +: W] = rand_op();
          end
          pending = 1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (in_valid && in_ready) pending = 0;
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    check("drain empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
